// File: rtl/scene_read_sequencer.sv
// Scene read sequencer: per-frame controller on the read side of the
// double-buffered scene store. It waits for a completed scene, streams its
// model instances through one registered valid/ready output stage, and
// reports frame completion or a skipped frame on timeout.

package scene_read_sequencer_pkg;
   typedef struct packed {
      logic [7:0]  model_id;
      logic [15:0] transform_addr;
   } modelinstance_t;
endpackage

module scene_read_sequencer
   import scene_read_sequencer_pkg::*;
#(
   parameter int TRANSFORM_COUNT = 50,
   parameter int TIMEOUT_CYCLES  = 1024,
   localparam int CNT_W = $clog2(TRANSFORM_COUNT + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             frame_start,
   input  logic             sb_read_valid,
   input  modelinstance_t   sb_read_transform,
   input  logic             sb_read_done,
   output logic             sb_read_en,
   output logic             out_valid,
   input  logic             out_ready,
   output modelinstance_t   out_instance,
   output logic             out_last,
   output logic             frame_busy,
   output logic             frame_done,
   output logic             frame_skipped,
   output logic [CNT_W-1:0] instance_count
);

   // Wide enough to hold TIMEOUT_CYCLES-1 even when TIMEOUT_CYCLES is 1.
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SCENE,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   state_t          state;
   logic [TO_W-1:0] timeout_cnt;
   logic            timeout_hit;
   logic            handshake;

   // The pop is combinational so that a freed output slot can be refilled
   // in the same cycle it is drained, giving one instance per cycle.
   assign sb_read_en  = (state == STREAM) && sb_read_valid && (!out_valid || out_ready);
   assign handshake   = out_valid && out_ready;
   // The counter value about to be written reaches the final wait cycle.
   assign timeout_hit = (int'(timeout_cnt) + 1) >= (TIMEOUT_CYCLES - 1);

   // Frame FSM together with the output register and the status outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         timeout_cnt    <= '0;
         out_valid      <= 1'b0;
         out_instance   <= '0;
         out_last       <= 1'b0;
         frame_busy     <= 1'b0;
         frame_done     <= 1'b0;
         frame_skipped  <= 1'b0;
         instance_count <= '0;
      end else begin
         frame_done <= 1'b0;

         if (handshake && (instance_count != CNT_W'(TRANSFORM_COUNT))) begin
            instance_count <= instance_count + 1'b1;
         end

         case (state)
            IDLE: begin
               if (frame_start) begin
                  state          <= WAIT_SCENE;
                  frame_busy     <= 1'b1;
                  frame_skipped  <= 1'b0;
                  instance_count <= '0;
                  timeout_cnt    <= '0;
               end
            end

            WAIT_SCENE: begin
               if (sb_read_valid) begin
                  state <= STREAM;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
                  if (timeout_hit) begin
                     state         <= DONE;
                     frame_skipped <= 1'b1;
                  end
               end
            end

            STREAM: begin
               if (sb_read_en) begin
                  out_instance <= sb_read_transform;
                  out_valid    <= 1'b1;
                  out_last     <= sb_read_done;
                  if (sb_read_done) begin
                     state <= DRAIN;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            end

            DRAIN: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  state     <= DONE;
               end
            end

            DONE: begin
               frame_done <= 1'b1;
               frame_busy <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scene_read_sequencer.sv
// Testbench for scene_read_sequencer: a small scene buffer model feeds the
// sequencer, the stimulus pushes expected instances into a scoreboard queue,
// and a negedge monitor compares every presented output against it.

module tb_scene_read_sequencer;
   import scene_read_sequencer_pkg::*;

   logic           clk;
   logic           rstn;
   logic           frame_start;
   logic           sb_read_valid;
   modelinstance_t sb_read_transform;
   logic           sb_read_done;
   logic           sb_read_en;
   logic           out_valid;
   logic           out_ready;
   modelinstance_t out_instance;
   logic           out_last;
   logic           frame_busy;
   logic           frame_done;
   logic           frame_skipped;
   logic [5:0]     instance_count;

   typedef struct {
      modelinstance_t inst;
      logic           last;
   } exp_t;

   exp_t           exp_q[$];
   int             exp_rd;
   int             pop_q[$];
   int             hs_q[$];
   int             done_q[$];
   int             cyc;
   int             n_checks;
   int             n_pass;

   modelinstance_t scene_mem[8];
   int             scene_len;
   int             rd_idx;
   logic           scene_loaded;
   logic           load_req;

   scene_read_sequencer #(
      .TRANSFORM_COUNT(50),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .frame_start      (frame_start),
      .sb_read_valid    (sb_read_valid),
      .sb_read_transform(sb_read_transform),
      .sb_read_done     (sb_read_done),
      .sb_read_en       (sb_read_en),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instance     (out_instance),
      .out_last         (out_last),
      .frame_busy       (frame_busy),
      .frame_done       (frame_done),
      .frame_skipped    (frame_skipped),
      .instance_count   (instance_count)
   );

   // Free-running clock and a cycle index that advances on each rising edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc++;
   end

   // Scene buffer model: presents the entry at the read index and frees the
   // scene on its last pop.
   assign sb_read_valid     = scene_loaded;
   assign sb_read_transform = scene_mem[rd_idx];
   assign sb_read_done      = scene_loaded && (rd_idx == scene_len - 1);

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scene_loaded <= 1'b0;
         rd_idx       <= 0;
      end else if (load_req && !scene_loaded) begin
         scene_loaded <= 1'b1;
         rd_idx       <= 0;
      end else if (sb_read_en && scene_loaded) begin
         if (rd_idx == scene_len - 1) begin
            scene_loaded <= 1'b0;
            rd_idx       <= 0;
         end else begin
            rd_idx <= rd_idx + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: compares each presented output with the scoreboard head,
   // retires it on a handshake, and logs pops, handshakes and frame_done.
   always @(negedge clk) begin
      if (!rstn) begin
         exp_rd = exp_q.size();
      end else begin
         if (out_valid) begin
            if (exp_rd >= exp_q.size()) begin
               checkOutput("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
               checkOutput("out_instance", {8'h00, out_instance}, {8'h00, exp_q[exp_rd].inst});
               checkOutput("out_last", 32'(out_last), 32'(exp_q[exp_rd].last));
               if (out_ready) begin
                  exp_rd++;
                  hs_q.push_back(cyc);
               end
            end
            if (!out_ready) begin
               checkOutput("no_pop_while_stalled", 32'(sb_read_en), 32'd0);
            end
         end
         if (sb_read_en) begin
            pop_q.push_back(cyc);
         end
         if (frame_done) begin
            done_q.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads an n-entry scene into the buffer model and queues its expected outputs.
   task automatic loadScene(input int n, input int sid);
      exp_t e;
      scene_len = n;
      for (int i = 0; i < n; i++) begin
         scene_mem[i] = '{model_id: 8'(sid * 16 + i), transform_addr: 16'(16'hA000 + sid * 256 + i * 4)};
         e.inst = scene_mem[i];
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   // One-cycle frame_start pulse; returns the cycle in which it was high.
   task automatic applyStimulus(output int start_cyc);
      frame_start = 1'b1;
      start_cyc   = cyc;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic waitDone(input int budget, output int done_cyc);
      int d0;
      int k;
      d0 = done_q.size();
      k  = 0;
      while (done_q.size() == d0 && k < budget) begin
         tick();
         k++;
      end
      n_checks++;
      if (done_q.size() > d0) begin
         n_pass++;
         done_cyc = done_q[d0];
      end else begin
         $display("[TB] FAIL frame_done_timeout: got no frame_done, expected one within %0d cycles", budget);
         done_cyc = -1;
      end
   endtask

   // Directed test sequence.
   initial begin
      int c;
      int dc;
      int p0;
      int h0;
      int d0;

      cyc         = 0;
      n_checks    = 0;
      n_pass      = 0;
      exp_rd      = 0;
      rstn        = 1'b0;
      frame_start = 1'b0;
      out_ready   = 1'b1;
      load_req    = 1'b0;
      scene_len   = 1;
      for (int i = 0; i < 8; i++) begin
         scene_mem[i] = '0;
      end

      tick();
      tick();
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_sb_read_en", 32'(sb_read_en), 32'd0);
      checkOutput("reset_frame_busy", 32'(frame_busy), 32'd0);
      checkOutput("reset_instance_count", 32'(instance_count), 32'd0);
      rstn = 1'b1;
      tick();

      $display("[TB] 3-instance scene, out_ready held high");
      loadScene(3, 1);
      p0 = pop_q.size();
      h0 = hs_q.size();
      applyStimulus(c);
      waitDone(40, dc);
      checkOutput("t1_pop_count", 32'(pop_q.size() - p0), 32'd3);
      checkOutput("t1_first_pop_cycle", 32'(pop_q[p0]), 32'(c + 2));
      checkOutput("t1_last_pop_cycle", 32'(pop_q[p0 + 2]), 32'(c + 4));
      checkOutput("t1_first_out_cycle", 32'(hs_q[h0]), 32'(c + 3));
      checkOutput("t1_last_out_cycle", 32'(hs_q[h0 + 2]), 32'(c + 5));
      checkOutput("t1_frame_done_cycle", 32'(dc), 32'(c + 7));
      checkOutput("t1_instance_count", 32'(instance_count), 32'd3);
      checkOutput("t1_frame_skipped", 32'(frame_skipped), 32'd0);

      $display("[TB] 3-instance scene, out_ready 1,0,0,1,1");
      loadScene(3, 2);
      h0 = hs_q.size();
      applyStimulus(c);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      out_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b1;
      waitDone(40, dc);
      checkOutput("t2_handshakes", 32'(hs_q.size() - h0), 32'd3);
      checkOutput("t2_last_out_cycle", 32'(hs_q[h0 + 2]), 32'(c + 7));
      checkOutput("t2_frame_done_cycle", 32'(dc), 32'(c + 9));
      checkOutput("t2_instance_count", 32'(instance_count), 32'd3);

      $display("[TB] no scene ready, timeout of 8 cycles");
      p0 = pop_q.size();
      applyStimulus(c);
      waitDone(40, dc);
      checkOutput("t3_frame_done_cycle", 32'(dc), 32'(c + 9));
      checkOutput("t3_frame_skipped", 32'(frame_skipped), 32'd1);
      checkOutput("t3_no_pops", 32'(pop_q.size() - p0), 32'd0);
      checkOutput("t3_instance_count", 32'(instance_count), 32'd0);

      $display("[TB] single-instance scene");
      loadScene(1, 3);
      p0 = pop_q.size();
      applyStimulus(c);
      waitDone(40, dc);
      checkOutput("t4_pop_count", 32'(pop_q.size() - p0), 32'd1);
      checkOutput("t4_frame_done_cycle", 32'(dc), 32'(c + 5));
      checkOutput("t4_instance_count", 32'(instance_count), 32'd1);
      checkOutput("t4_frame_skipped", 32'(frame_skipped), 32'd0);

      $display("[TB] frame_start repeated during STREAM");
      loadScene(3, 4);
      d0 = done_q.size();
      applyStimulus(c);
      tick();
      applyStimulus(p0);
      waitDone(40, dc);
      for (int i = 0; i < 15; i++) begin
         tick();
      end
      checkOutput("t5_frame_done_count", 32'(done_q.size() - d0), 32'd1);
      checkOutput("t5_frame_done_cycle", 32'(dc), 32'(c + 7));
      checkOutput("t5_instance_count", 32'(instance_count), 32'd3);
      checkOutput("t5_frame_busy_idle", 32'(frame_busy), 32'd0);

      $display("[TB] reset in the middle of a 5-instance scene");
      loadScene(5, 5);
      applyStimulus(c);
      tick();
      tick();
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("rst_sb_read_en", 32'(sb_read_en), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_out_instance", {8'h00, out_instance}, 32'd0);
      checkOutput("rst_frame_busy", 32'(frame_busy), 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_frame_skipped", 32'(frame_skipped), 32'd0);
      checkOutput("rst_instance_count", 32'(instance_count), 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      p0 = pop_q.size();
      tick();
      tick();
      checkOutput("post_rst_frame_busy", 32'(frame_busy), 32'd0);
      checkOutput("post_rst_no_pops", 32'(pop_q.size() - p0), 32'd0);

      loadScene(2, 6);
      applyStimulus(c);
      waitDone(40, dc);
      checkOutput("post_rst_instance_count", 32'(instance_count), 32'd2);
      checkOutput("post_rst_frame_done_cycle", 32'(dc), 32'(c + 6));
      tick();
      checkOutput("scoreboard_drained", 32'(exp_q.size() - exp_rd), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute bound on simulation time.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no end of test, expected finish before 200000");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
